// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer on the free-running reference clock: pulses the PLL reset, waits for
// lock with timeout, qualifies stability, then releases sys_rst_n. Optional macro: PLL_LOCK_FILTER_EN.
module pll_lock_supervisor #(
    parameter int RST_CYCLES          = 20,
    parameter int LOCK_STABLE_CYCLES  = 2000,
    parameter int LOCK_TIMEOUT_CYCLES = 20000,
    parameter int CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] loss_cnt,
    output logic [7:0] timeout_cnt
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sync1_reg, sync2_reg;
    logic             pll_rst_reg, run_reg;
    logic [7:0]       loss_cnt_reg, timeout_cnt_reg;
    logic             lk_s, loss_event, loss_inc, timeout_inc;

    assign lk_s = sync2_reg;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pll_locked;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef PLL_LOCK_FILTER_EN
    // A loss is declared only on the 4th consecutive low lk_s cycle while running.
    logic [1:0] low_cnt_reg, low_cnt_next;

    always_comb begin
        low_cnt_next = 2'd0;
        if (state_reg == RUN && !lk_s)
            low_cnt_next = low_cnt_reg + 2'd1;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            low_cnt_reg <= 2'd0;
        else
            low_cnt_reg <= low_cnt_next;
    end

    assign loss_event = (state_reg == RUN) && !lk_s && (low_cnt_reg == 2'd3);
`else
    assign loss_event = (state_reg == RUN) && !lk_s;
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + CNT_W'(1);
        loss_inc    = 1'b0;
        timeout_inc = 1'b0;
        case (state_reg)
            RESET_PLL: begin
                if (cnt_reg == RST_LAST)
                    state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (relock_req)
                    state_next = RESET_PLL;
                else if (lk_s)
                    state_next = STABLE;
                else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next  = RESET_PLL;
                    timeout_inc = 1'b1;
                end
            end
            STABLE: begin
                if (relock_req)
                    state_next = RESET_PLL;
                else if (!lk_s)
                    state_next = WAIT_LOCK;
                else if (cnt_reg == STABLE_LAST)
                    state_next = RUN;
            end
            RUN: begin
                cnt_next = cnt_reg;
                if (loss_event) begin
                    state_next = RESET_PLL;
                    loss_inc   = 1'b1;
                end else if (relock_req)
                    state_next = RESET_PLL;
            end
            default: state_next = RESET_PLL;
        endcase
        if (state_next != state_reg)
            cnt_next = '0;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RESET_PLL;
            cnt_reg         <= '0;
            pll_rst_reg     <= 1'b1;
            run_reg         <= 1'b0;
            loss_cnt_reg    <= 8'd0;
            timeout_cnt_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pll_rst_reg <= (state_next == RESET_PLL);
            run_reg     <= (state_next == RUN);
            if (loss_inc && loss_cnt_reg != 8'hFF)
                loss_cnt_reg <= loss_cnt_reg + 8'd1;
            if (timeout_inc && timeout_cnt_reg != 8'hFF)
                timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
        end
    end

    assign pll_rst     = pll_rst_reg;
    assign sys_rst_n   = run_reg;
    assign ready       = run_reg;
    assign state       = state_reg;
    assign loss_cnt    = loss_cnt_reg;
    assign timeout_cnt = timeout_cnt_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Table-driven, scoreboarded bench for pll_lock_supervisor (RST=4, STABLE=8, TIMEOUT=32).
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst_n, ready;
    logic [1:0] state;
    logic [7:0] loss_cnt, timeout_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_supervisor #(
        .RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32), .CNT_W(16)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .relock_req(relock_req),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .state(state),
        .loss_cnt(loss_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic       rst_n, lk, req;
        int         n;
        logic [1:0] st;
        logic       prst, rdy;
        logic [7:0] loss, to;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       prst, rdy;
        logic [7:0] loss, to;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic void v(input logic r, input logic l, input logic q, input int n,
                              input logic [1:0] st, input logic p, input logic d,
                              input logic [7:0] ls, input logic [7:0] t);
        vec_t x;
        x.rst_n = r; x.lk = l; x.req = q; x.n = n;
        x.st = st; x.prst = p; x.rdy = d; x.loss = ls; x.to = t;
        vecs.push_back(x);
    endfunction

    // Standard re-sequence tail from RESET_PLL (cnt 0) to RUN with lock held high.
    function automatic void tail(input logic [7:0] ls, input logic [7:0] t);
        v(1, 1, 0, 3, 0, 1, 0, ls, t);
        v(1, 1, 0, 1, 1, 0, 0, ls, t);
        v(1, 1, 0, 8, 2, 0, 0, ls, t);
        v(1, 1, 0, 1, 3, 0, 1, ls, t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] st, input logic p, input logic d,
                            input logic [7:0] ls, input logic [7:0] t);
        exp_t e;
        e.st = st; e.prst = p; e.rdy = d; e.loss = ls; e.to = t;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, " state"}, 32'(state), 32'(e.st));
        chk({tag, " pll_rst"}, 32'(pll_rst), 32'(e.prst));
        chk({tag, " ready"}, 32'(ready), 32'(e.rdy));
        chk({tag, " sys_rst_n"}, 32'(sys_rst_n), 32'(e.rdy));
        chk({tag, " loss_cnt"}, 32'(loss_cnt), 32'(e.loss));
        chk({tag, " timeout_cnt"}, 32'(timeout_cnt), 32'(e.to));
    endtask

    initial begin
        // No lock: re-pulse every 36 cycles, three timeouts.
        v(0, 0, 0, 1, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            v(1, 0, 0, 3, 0, 1, 0, 0, 8'(k - 1));
            v(1, 0, 0, 32, 1, 0, 0, 0, 8'(k - 1));
            v(1, 0, 0, 1, 0, 1, 0, 0, 8'(k));
        end
        // relock_req on the timeout edge wins: no timeout counted.
        v(1, 0, 0, 3, 0, 1, 0, 0, 3);
        v(1, 0, 0, 32, 1, 0, 0, 0, 3);
        v(1, 0, 1, 1, 0, 1, 0, 0, 3);
        // relock_req on the STABLE completion edge wins: back to RESET_PLL.
        v(1, 1, 0, 3, 0, 1, 0, 0, 3);
        v(1, 1, 0, 1, 1, 0, 0, 0, 3);
        v(1, 1, 0, 8, 2, 0, 0, 0, 3);
        v(1, 1, 1, 1, 0, 1, 0, 0, 3);
        // Clean start from rst_n with lock held: ready on the 13th edge.
        v(0, 1, 0, 1, 0, 1, 0, 0, 0);
        v(1, 1, 0, 3, 0, 1, 0, 0, 0);
        v(1, 1, 0, 1, 1, 0, 0, 0, 0);
        v(1, 1, 0, 8, 2, 0, 0, 0, 0);
        v(1, 1, 0, 3, 3, 0, 1, 0, 0);
        // relock_req in RUN: ready falls next edge, returns 13 edges later.
        v(1, 1, 1, 1, 0, 1, 0, 0, 0);
        tail(0, 0);
        // relock_req repeated while in RESET_PLL is ignored.
        v(1, 1, 1, 1, 0, 1, 0, 0, 0);
        v(1, 1, 1, 1, 0, 1, 0, 0, 0);
        v(1, 1, 0, 2, 0, 1, 0, 0, 0);
        v(1, 1, 0, 1, 1, 0, 0, 0, 0);
        v(1, 1, 0, 8, 2, 0, 0, 0, 0);
        v(1, 1, 0, 1, 3, 0, 1, 0, 0);
        // One-cycle lock drop mid-STABLE: back to WAIT_LOCK, STABLE restarts.
        v(1, 1, 1, 1, 0, 1, 0, 0, 0);
        v(1, 1, 0, 3, 0, 1, 0, 0, 0);
        v(1, 1, 0, 1, 1, 0, 0, 0, 0);
        v(1, 1, 0, 3, 2, 0, 0, 0, 0);
        v(1, 0, 0, 1, 2, 0, 0, 0, 0);
        v(1, 1, 0, 1, 2, 0, 0, 0, 0);
        v(1, 1, 0, 1, 1, 0, 0, 0, 0);
        v(1, 1, 0, 8, 2, 0, 0, 0, 0);
        v(1, 1, 0, 1, 3, 0, 1, 0, 0);
`ifdef PLL_LOCK_FILTER_EN
        // Two-cycle glitch ignored; a long loss with relock_req on the same edge is counted.
        v(1, 0, 0, 2, 3, 0, 1, 0, 0);
        v(1, 1, 0, 4, 3, 0, 1, 0, 0);
        v(1, 0, 0, 5, 3, 0, 1, 0, 0);
        v(1, 0, 1, 1, 0, 1, 0, 1, 0);
`else
        // Two-cycle loss with relock_req on the loss edge: counted as a loss.
        v(1, 0, 0, 2, 3, 0, 1, 0, 0);
        v(1, 1, 1, 1, 0, 1, 0, 1, 0);
`endif
        tail(1, 0);

        // Reset value before release.
        rst_n = 1'b0;
        @(posedge refclk); #1;
        push_exp(0, 1, 0, 0, 0);
        pop_cmp("reset");

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].n; r++) begin
                @(negedge refclk);
                rst_n      = vecs[i].rst_n;
                pll_locked = vecs[i].lk;
                relock_req = vecs[i].req;
                push_exp(vecs[i].st, vecs[i].prst, vecs[i].rdy, vecs[i].loss, vecs[i].to);
                @(posedge refclk); #1;
                pop_cmp($sformatf("vec%0d.%0d", i, r));
            end
            $display("vec %0d: rst_n=%0b lk=%0b req=%0b x%0d -> state=%0d pll_rst=%0b ready=%0b loss=%0d to=%0d",
                     i, vecs[i].rst_n, vecs[i].lk, vecs[i].req, vecs[i].n,
                     state, pll_rst, ready, loss_cnt, timeout_cnt);
        end

        // Saturation: 300 timeouts leave timeout_cnt at 255.
        @(negedge refclk);
        rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
        @(negedge refclk);
        rst_n = 1'b1;
        push_exp(0, 1, 0, 0, 255);
        repeat (300 * 36) @(posedge refclk);
        #1;
        pop_cmp("saturate");
        $display("saturate: 300 timeouts -> timeout_cnt=%0d state=%0d", timeout_cnt, state);

        // Lock arrives, reach STABLE, then assert rst_n asynchronously mid-STABLE.
        @(negedge refclk);
        pll_locked = 1'b1;
        push_exp(2, 0, 0, 0, 255);
        repeat (7) @(posedge refclk);
        #1;
        pop_cmp("mid_stable");
        @(negedge refclk);
        rst_n = 1'b0;
        push_exp(0, 1, 0, 0, 0);
        #1;
        pop_cmp("async_reset");
        $display("async reset mid-STABLE -> state=%0d pll_rst=%0b ready=%0b to=%0d",
                 state, pll_rst, ready, timeout_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
